// File: rtl/chunked_wide_adder.sv
// chunked_wide_adder: multi-cycle wide adder built around a CHUNK-bit
// carry-lookahead adder. Operands are captured once, then one slice per
// cycle is added, with the slice carry registered between cycles.
// Optional feature macro: CHUNKED_ADDER_OVERFLOW_EN adds a registered
// signed-overflow output (ovf).

module carry_lookahead_adder #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N-1:0] g_s;
  logic [N-1:0] p_s;
  logic [N:0]   c_s;

  // Each carry is a flat sum-of-products of generate/propagate terms
  always_comb begin
    logic carry_v;
    logic prod_v;
    carry_v = 1'b0;
    prod_v  = 1'b1;
    g_s     = a & b;
    p_s     = a ^ b;
    c_s     = '0;
    c_s[0]  = cin;
    for (int i = 0; i < N; i++) begin
      carry_v = 1'b0;
      prod_v  = 1'b1;
      for (int j = i; j >= 0; j--) begin
        carry_v = carry_v | (prod_v & g_s[j]);
        prod_v  = prod_v & p_s[j];
      end
      c_s[i+1] = carry_v | (prod_v & cin);
    end
    sum  = p_s ^ c_s[N-1:0];
    cout = c_s[N];
  end

endmodule

module chunked_wide_adder #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef CHUNKED_ADDER_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int NUM_CHUNKS = WIDTH / CHUNK;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  if ((WIDTH % CHUNK) != 0) begin : g_width_check
    $error("chunked_wide_adder: WIDTH must be an integer multiple of CHUNK");
  end

  logic [1:0]       state_r;
  logic [IDX_W-1:0] idx_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
  logic             ovf_r;
`endif

  logic [CHUNK-1:0] cla_a_s;
  logic [CHUNK-1:0] cla_b_s;
  logic [CHUNK-1:0] cla_sum_s;
  logic             cla_cout_s;

  // Select the operand slice addressed by the chunk index
  always_comb begin
    cla_a_s = a_r[idx_r*CHUNK +: CHUNK];
    cla_b_s = b_r[idx_r*CHUNK +: CHUNK];
  end

  carry_lookahead_adder #(.N(CHUNK)) u_cla (
    .a    (cla_a_s),
    .b    (cla_b_s),
    .cin  (carry_r),
    .sum  (cla_sum_s),
    .cout (cla_cout_s)
  );

  // Control FSM, operand capture and per-slice result accumulation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      idx_r       <= '0;
      a_r         <= '0;
      b_r         <= '0;
      carry_r     <= 1'b0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
      ovf_r       <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid && in_ready_r) begin
            a_r        <= a;
            b_r        <= b;
            carry_r    <= cin;
            idx_r      <= '0;
            state_r    <= ST_ADD;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ADD: begin
          sum_r[idx_r*CHUNK +: CHUNK] <= cla_sum_s;
          carry_r                     <= cla_cout_s;
          if (idx_r == LAST_IDX) begin
            // The MSB slice closes the transaction and publishes the carry
            cout_r      <= cla_cout_s;
            idx_r       <= '0;
            state_r     <= ST_DONE;
            out_valid_r <= 1'b1;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
            ovf_r       <= cla_cout_s ^ (a_r[WIDTH-1] ^ b_r[WIDTH-1] ^ cla_sum_s[CHUNK-1]);
`endif
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          idx_r       <= '0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
  assign ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_chunked_wide_adder.sv
// Self-checking bench for chunked_wide_adder (WIDTH=64, CHUNK=16).
// Reference results come from plain 65-bit arithmetic; the optional ovf
// output is checked with the sign rule when CHUNKED_ADDER_OVERFLOW_EN is set.

module tb_chunked_wide_adder;

  localparam int WIDTH = 64;
  localparam int CHUNK = 16;
  localparam int NC    = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic             cin = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             in_ready;
  logic             out_valid;
  logic             busy;
  logic             cout;
  logic [WIDTH-1:0] sum;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
  logic             ovf;
`endif

  int tests = 0;
  int fails = 0;

  chunked_wide_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
`ifdef CHUNKED_ADDER_OVERFLOW_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic c);
    return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
  endfunction

  function automatic logic ref_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic [WIDTH-1:0] s);
    return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_ready_wait"}, 64'(in_ready), 64'd1);
  endtask

  task automatic wait_out(input string tag, input int exp_lat);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(exp_lat));
  endtask

  // Full transaction: accept, count latency, check result, drain.
  task automatic run_txn(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v, input logic tc,
                         input string tag);
    logic [WIDTH:0] exp;
    wait_ready(tag);
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
    exp = ref_add(ta, tb_v, tc);
    tick();
    in_valid = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    cin = 1'($urandom);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    wait_out(tag, NC);
    check({tag, "_sum"}, sum, exp[WIDTH-1:0]);
    check({tag, "_cout"}, 64'(cout), 64'(exp[WIDTH]));
`ifdef CHUNKED_ADDER_OVERFLOW_EN
    check({tag, "_ovf"}, 64'(ovf), 64'(ref_ovf(ta, tb_v, exp[WIDTH-1:0])));
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drain_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_drain_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [WIDTH:0]   exp1;
    logic [WIDTH:0]   exp2;
    logic [WIDTH-1:0] a2;
    logic [WIDTH-1:0] b2;
    logic [WIDTH:0]   expq[$];
    int               acc;
    int               got;
    int               t_prev;

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_sum", sum, 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
`ifdef CHUNKED_ADDER_OVERFLOW_EN
    check("rst_ovf", 64'(ovf), 64'd0);
`endif
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", 64'(in_ready), 64'd1);

    // Directed arithmetic cases
    run_txn(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, "all_ones_plus1");
    run_txn(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, "slice_carry");
    run_txn(64'h0, 64'h0, 1'b1, "cin_only");
    run_txn(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, "max_max_cin");

    // Randomized transactions
    for (int k = 0; k < 16; k++) begin
      run_txn({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), "rand");
    end

    // Backpressure: result held while out_ready low, new offer ignored
    wait_ready("bp");
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'b1;
    exp1 = ref_add(a, b, cin);
    in_valid = 1'b1;
    tick();
    a2 = {$urandom, $urandom}; b2 = {$urandom, $urandom};
    a = a2; b = b2; cin = 1'b0;
    exp2 = ref_add(a2, b2, 1'b0);
    wait_out("bp", NC);
    for (int k = 0; k < 10; k++) begin
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_sum", sum, exp1[WIDTH-1:0]);
      check("bp_hold_cout", 64'(cout), 64'(exp1[WIDTH]));
      check("bp_hold_in_ready", 64'(in_ready), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    check("bp_release_busy", 64'(busy), 64'd0);
    tick();
    in_valid = 1'b0;
    check("bp_second_busy", 64'(busy), 64'd1);
    wait_out("bp_second", NC);
    check("bp_second_sum", sum, exp2[WIDTH-1:0]);
    check("bp_second_cout", 64'(cout), 64'(exp2[WIDTH]));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in the middle of ADD discards the transaction
    wait_ready("mid_rst");
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'hFFFF_FFFF_FFFF_FFFF; cin = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_sum", sum, 64'd0);
    check("mid_rst_cout", 64'(cout), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("mid_rst_no_pulse", 64'(out_valid), 64'd0);
    end
    run_txn(64'd5, 64'd7, 1'b0, "post_rst");

    // Back-to-back: three results spaced NC+2 cycles apart
    wait_ready("b2b");
    out_ready = 1'b1;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'($urandom);
    in_valid = 1'b1;
    acc = 0; got = 0; t_prev = -1;
    for (int cyc = 0; cyc < 60 && got < 3; cyc++) begin
      if (in_valid && in_ready) begin
        expq.push_back(ref_add(a, b, cin));
        acc++;
        tick();
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'($urandom);
        if (acc >= 3) in_valid = 1'b0;
      end else begin
        tick();
      end
      if (out_valid) begin
        if (expq.size() > 0) begin
          exp1 = expq.pop_front();
          check("b2b_sum", sum, exp1[WIDTH-1:0]);
          check("b2b_cout", 64'(cout), 64'(exp1[WIDTH]));
        end else begin
          check("b2b_unexpected_result", 64'd1, 64'd0);
        end
        if (t_prev >= 0) check("b2b_spacing", 64'(cyc - t_prev), 64'(NC + 2));
        t_prev = cyc;
        got++;
      end
    end
    in_valid = 1'b0;
    check("b2b_count", 64'(got), 64'd3);
    tick();
    out_ready = 1'b0;

`ifdef CHUNKED_ADDER_OVERFLOW_EN
    // Signed overflow corner cases
    run_txn(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, "ovf_pos");
    check("ovf_pos_flag", 64'(ovf), 64'd1);
    run_txn(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, "ovf_neg");
    check("ovf_neg_flag", 64'(ovf), 64'd1);
    run_txn(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, "ovf_none");
    check("ovf_none_flag", 64'(ovf), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/chunked_wide_adder.md
Name: chunked_wide_adder

Overview:
- Multi-cycle wide adder. Accepts WIDTH-bit operands via valid/ready handshake and splits them into CHUNK-bit slices.
- Feeds one slice per cycle into an internal carry_lookahead_adder #(.N(CHUNK)); registers each cout and returns it as cin of the next slice.
- Trades latency for a short combinational carry path. Sits directly upstream of the CLA and consumes its sum/cout.

Parameters:
- WIDTH, 64, total operand width; must be an integer multiple of CHUNK.
- CHUNK, 16, slice width; also the N of the internal CLA.
- NUM_CHUNKS (localparam), WIDTH/CHUNK, number of ADD cycles per transaction.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand transaction offered
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in to LSB slice
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  registered result
- cout  output  1  carry-out of MSB slice
- busy  output  1  high in ADD or DONE

Behaviour:
- Reset (rst_n low at a rising edge):
  - State goes to IDLE and chunk index to 0.
  - sum, cout, out_valid and busy are 0; in_ready is 1 after the edge.
  - Operand and carry registers clear.
  - Reset mid-ADD or mid-DONE discards the partial or pending result; no output pulse.
- States: IDLE, ADD, DONE.
- IDLE:
  - in_ready=1, out_valid=0, busy=0.
  - On in_valid & in_ready at an edge: capture a, b, cin into internal regs; idx<=0; go to ADD.
- ADD:
  - in_ready=0, busy=1.
  - CLA inputs are a_reg[idx*CHUNK +: CHUNK], b_reg[same], carry_reg (cin for idx 0).
  - Each edge: sum[idx slice]<=CLA sum; carry_reg<=CLA cout; idx<=idx+1.
  - When idx==NUM_CHUNKS-1: cout<=CLA cout, go to DONE.
- DONE:
  - out_valid=1, busy=1, in_ready=0.
  - sum and cout are held stable while out_ready is low, for any number of cycles.
  - On out_ready at an edge: go to IDLE, out_valid<=0. sum and cout keep their last values until the next result is written.
- Latency: out_valid is first high after exactly NUM_CHUNKS edges following the accepting edge.
- Throughput: back-to-back with out_ready held high gives one result per NUM_CHUNKS+2 cycles. in_ready is never high in DONE; no bypass.
- in_valid outside IDLE is ignored; a, b and cin may change freely after acceptance.
- Arithmetic: unsigned modulo 2^WIDTH; {cout,sum} = a + b + cin exactly. Full carry propagation across all slices is required (e.g. all-ones + 1).
- Elaboration: WIDTH % CHUNK != 0 is an error, via a generate-time $error. NUM_CHUNKS==1 is legal: single ADD cycle.
- idx width is $clog2(NUM_CHUNKS), minimum 1.

Optional Feature:
- Macro: CHUNKED_ADDER_OVERFLOW_EN.
- When defined:
  - Extra output port ovf (output, 1): signed two's-complement overflow.
  - ovf = cout ^ (a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ sum[WIDTH-1]), registered on the final ADD edge.
  - Valid with out_valid, held in DONE, reset to 0.
- When undefined: the ovf port and its logic do not exist; all other behaviour is identical.

Test Plan:
1. WIDTH=64, CHUNK=16. a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, cin=0 -> sum=0x0, cout=1. out_valid rises exactly 4 edges after accept.
2. a=0x0000_FFFF_0000_FFFF, b=0x0000_0001_0000_0001, cin=0 -> sum=0x0001_0000_0001_0000, cout=0. Also a=0, b=0, cin=1 -> sum=0x1, cout=0.
3. Backpressure: result ready, out_ready low for 10 cycles, in_valid high with new operands -> out_valid, sum and cout stable; in_ready=0; new operands not taken. out_ready high -> IDLE next cycle, then the new operands are accepted.
4. Reset after 2 ADD cycles (rst_n low one cycle) -> next cycle out_valid=0, busy=0, sum=0, cout=0, in_ready=1. A following transaction a=5, b=7 -> sum=12, cout=0.
5. Back-to-back: out_ready and in_valid held high, 3 transactions -> out_valid pulses spaced exactly 6 cycles apart, all results correct.
6. With CHUNKED_ADDER_OVERFLOW_EN:
   - a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> sum=0x8000_0000_0000_0000, cout=0, ovf=1.
   - a=b=0x8000_0000_0000_0000 -> sum=0, cout=1, ovf=1.
   - a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> ovf=0.
